// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline-stage register: payload
// geometry, control-bit positions, occupancy encoding and counter widths.
package pipe_pkg;

  localparam int WORD_W      = 32;
  localparam int REGIDX_W    = 5;
  // Two data words plus a writeback register index.
  localparam int PAYLOAD_W   = 2 * WORD_W + REGIDX_W;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;

  localparam int PERF_CNT_W  = 32;
  localparam int FLUSH_CNT_W = 16;

  // Number of entries held by the two-entry skid storage.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  // True when the occupancy state holds at least one entry.
  function automatic logic occ_has_entry(input occ_e s);
    return (s != EMPTY);
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry skid storage (EMPTY/ONE/FULL). The head entry always sits in
// main_reg; a second entry accepted while the head is stalled lands in
// skid_reg. in_ready is a flop so the upstream ready path is cut.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int W = PAYLOAD_W + 2
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         flush_i,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  occ_e         state_reg, state_next;
  logic         ready_reg;
  logic [W-1:0] main_reg, skid_reg;
  logic         in_xfer, out_xfer;
  logic         main_load_in, main_load_skid, skid_load;

  assign in_xfer   = in_valid & ready_reg;
  assign out_xfer  = occ_has_entry(state_reg) & out_ready;
  assign in_ready  = ready_reg;
  assign out_valid = occ_has_entry(state_reg);
  assign out_data  = main_reg;

  // Next occupancy and which register captures which entry; flush wins.
  always_comb begin
    state_next     = state_reg;
    main_load_in   = 1'b0;
    main_load_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush_i) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (in_xfer) begin
            state_next   = ONE;
            main_load_in = 1'b1;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_load_in = 1'b1;
          end else if (in_xfer) begin
            state_next = FULL;
            skid_load  = 1'b1;
          end else if (out_xfer) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the head can leave.
          if (out_xfer) begin
            state_next     = ONE;
            main_load_skid = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // Occupancy register and its registered ready (low only when FULL).
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg <= EMPTY;
      ready_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      ready_reg <= (state_next != FULL);
    end
  end

  // Payload storage; written only on accepted entries, untouched by flush.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      main_reg <= '0;
      skid_reg <= '0;
    end else begin
      if (main_load_in) begin
        main_reg <= in_data;
      end else if (main_load_skid) begin
        main_reg <= skid_reg;
      end
      if (skid_load) begin
        skid_reg <= in_data;
      end
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with valid/ready handshake and flush.
// SKID=1 uses the two-entry skid storage (registered ready_o); SKID=0 uses
// a single register with combinational ready_o. ctrl_o is gated by valid_o
// so a discarded entry can never assert RegWrite downstream.
// Optional macro PIPE_STAGE_PERF_EN adds saturating stall/bubble/flush
// counters. rst_n_i asserts asynchronously and is expected to be released
// synchronously to clk_i.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = PAYLOAD_W,
  parameter int CTRL_W = 2,
  parameter int SKID   = 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0]  stall_cnt_o,
  output logic [PERF_CNT_W-1:0]  bubble_cnt_o,
  output logic [FLUSH_CNT_W-1:0] flush_cnt_o
`endif
);

  localparam int ENTRY_W = DATA_W + CTRL_W;

  logic [CTRL_W-1:0] ctrl_q;

  if (SKID != 0) begin : g_skid
    logic [ENTRY_W-1:0] out_entry;

    pipe_skid_buf #(.W(ENTRY_W)) u_skid (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .flush_i   (flush_i),
      .in_valid  (valid_i),
      .in_ready  (ready_o),
      .in_data   ({ctrl_i, data_i}),
      .out_valid (valid_o),
      .out_ready (ready_i),
      .out_data  (out_entry)
    );

    assign data_o = out_entry[DATA_W-1:0];
    assign ctrl_q = out_entry[ENTRY_W-1:DATA_W];
  end else begin : g_single
    logic              valid_reg;
    logic [DATA_W-1:0] data_reg;
    logic [CTRL_W-1:0] ctrl_reg;

    assign ready_o = ready_i | ~valid_reg;
    assign valid_o = valid_reg;
    assign data_o  = data_reg;
    assign ctrl_q  = ctrl_reg;

    // Valid bit: flush clears, accept sets, drain clears, stall holds.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        valid_reg <= 1'b0;
      end else if (flush_i) begin
        valid_reg <= 1'b0;
      end else if (valid_i && ready_o) begin
        valid_reg <= 1'b1;
      end else if (ready_i) begin
        valid_reg <= 1'b0;
      end
    end

    // Payload capture only on an accepted, non-flushed entry.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        data_reg <= '0;
        ctrl_reg <= '0;
      end else if (!flush_i && valid_i && ready_o) begin
        data_reg <= data_i;
        ctrl_reg <= ctrl_i;
      end
    end
  end

  // Every control bit is forced low whenever no valid entry is presented.
  for (genvar gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_gate
    assign ctrl_o[gi] = ctrl_q[gi] & valid_o;
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [PERF_CNT_W-1:0]  stall_cnt_reg, bubble_cnt_reg;
  logic [FLUSH_CNT_W-1:0] flush_cnt_reg;
  logic                   stall_evt, bubble_evt, flush_evt;

  assign stall_evt  = valid_o & ~ready_i;
  assign bubble_evt = ~valid_o & ~flush_i;
  assign flush_evt  = flush_i & (valid_o | valid_i);

  assign stall_cnt_o  = stall_cnt_reg;
  assign bubble_cnt_o = bubble_cnt_reg;
  assign flush_cnt_o  = flush_cnt_reg;

  // Saturating event counters; they stick at all-ones instead of wrapping.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_reg  <= '0;
      bubble_cnt_reg <= '0;
      flush_cnt_reg  <= '0;
    end else begin
      if (stall_evt && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + PERF_CNT_W'(1);
      end
      if (bubble_evt && (bubble_cnt_reg != '1)) begin
        bubble_cnt_reg <= bubble_cnt_reg + PERF_CNT_W'(1);
      end
      if (flush_evt && (flush_cnt_reg != '1)) begin
        flush_cnt_reg <= flush_cnt_reg + FLUSH_CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, elastic pipeline-stage register replacing the fixed, stall-only inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a data payload plus a control-bit vector between stages with a valid/ready handshake, flush, and an optional two-entry skid buffer for timing isolation.
- Sits between any two CPU pipeline stages; the hazard unit drives ready_i/flush_i.

Parameters:
- DATA_W, 69, payload width (e.g. two 32-bit words + 5-bit writeback register index).
- CTRL_W, 2, control-bit width (e.g. RegWrite, MemtoReg); forced to 0 when no valid entry.
- SKID, 1, 1 = two-entry skid buffer with registered ready_o; 0 = single register with combinational ready_o.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- valid_i  in  1  upstream has a valid entry.
- ready_o  out  1  stage can accept this cycle.
- data_i  in  DATA_W  upstream payload.
- ctrl_i  in  CTRL_W  upstream control bits.
- flush_i  in  1  discard all held entries and the entry offered this cycle.
- valid_o  out  1  output entry valid.
- ready_i  in  1  downstream accepts (0 = stall).
- data_o  out  DATA_W  output payload.
- ctrl_o  out  CTRL_W  output control; equals 0 whenever valid_o=0.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - valid_o=0, ctrl_o=0, data_o=0, skid entry invalid.
  - ready_o=1 from the first cycle after release.
- Transfers:
  - In-transfer: valid_i & ready_o at a rising edge.
  - Out-transfer: valid_o & ready_i at a rising edge.
- Latency: 1 cycle (in-transfer at edge N, data visible on data_o after edge N).
- Ordering: strict FIFO order. No entry is dropped or duplicated except by flush.
- SKID=1 (states EMPTY, ONE, FULL; occupancy 0/1/2):
  - EMPTY: in-transfer -> ONE.
  - ONE, in-transfer and no out-transfer -> FULL (entry lands in skid reg).
  - ONE, out-transfer and no in-transfer -> EMPTY.
  - ONE, simultaneous in- and out-transfer -> ONE (main reg reloaded directly).
  - FULL: ready_o=0. Out-transfer -> ONE, skid entry moves to main reg on the same edge.
  - ready_o is a pure flop output: ready_o = (state != FULL).
- SKID=0:
  - Single register; ready_o = ready_i | ~valid_o (combinational).
  - Holds its contents while ready_i=0 & valid_o=1.
- Flush:
  - flush_i=1 at an edge -> state EMPTY, valid_o=0, ctrl_o=0. The in-transfer that cycle is discarded.
  - Flush has priority over all transfers.
  - data_o holds its last value (don't-care when invalid).
- ctrl_o gating: registered control bits ANDed with valid_o, so a stalled-then-flushed entry never emits RegWrite.
- X-safety: data_i is not sampled when valid_i=0. Its value is ignored.
- Reset mid-operation: all entries lost immediately (async); no partial state.

Optional Feature:
- Macro PIPE_STAGE_PERF_EN.
- When defined, adds outputs:
  - stall_cnt_o [31:0]: counts cycles with valid_o & ~ready_i.
  - bubble_cnt_o [31:0]: counts cycles with ~valid_o & ~flush_i.
  - flush_cnt_o [15:0]: counts flush_i cycles in which at least one entry was held or offered.
- Counter behaviour: all reset to 0 on rst_n_i; saturate at all-ones (no wrap).
- When undefined: ports and logic are absent; handshake behaviour is identical.

Decomposition:
- Shared package pipe_pkg:
  - Payload widths (WORD_W=32, REGIDX_W=5).
  - Control-bit index constants (CTRL_REGWRITE=0, CTRL_MEMTOREG=1).
  - Occupancy state encoding (EMPTY, ONE, FULL).
  - PERF_CNT_W=32.
- One sub-module, pipe_skid_buf: the two-entry FULL/ONE/EMPTY storage with flush, instantiated under SKID=1.
- pipe_stage_reg selects between pipe_skid_buf and the single-register path, and adds ctrl gating and perf counters.

Test Plan:
- Reset/idle: hold rst_n_i=0 3 cycles, then release -> valid_o=0, ctrl_o=0, ready_o=1. Send data 0x1234 with ctrl 2'b11, ready_i=1 -> data_o=0x1234 and ctrl_o=2'b11 one cycle later.
- Back-to-back streaming: values 1..8 on consecutive cycles, ready_i=1 -> outputs 1..8 on consecutive cycles, no bubbles. With PIPE_STAGE_PERF_EN, bubble_cnt_o increments only before the first output.
- Stall/skid fill (SKID=1): send A, B, C with ready_i=0 from cycle 1 -> ready_o drops to 0 after B is accepted; C is held upstream. Raise ready_i -> A, B, C emerge in order; stall_cnt_o equals the stalled cycles.
- Flush with full skid: occupancy 2 (A, B) plus C offered, flush_i=1 one cycle -> next cycle valid_o=0, ctrl_o=0, ready_o=1. Subsequent D emerges alone; A, B, C are never seen.
- SKID=0 stall: valid_o=1 holding X, ready_i=0, valid_i=1 with Y -> ready_o=0 and X held. Raise ready_i -> ready_o=1 in the same cycle, Y follows X.
- Async reset mid-stream: assert rst_n_i between clock edges while occupancy is 2 -> valid_o=0 and ctrl_o=0 immediately, without waiting for a clock edge.
